// File: rtl/alu_pkg.sv
// Shared types for the ALU execution unit: opcodes, FSM states and the flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_OR    = 4'd1,
    OP_AND   = 4'd2,
    OP_XOR   = 4'd3,
    OP_SUB   = 4'd4,
    OP_ADC   = 4'd5,
    OP_NOT_A = 4'd6,
    OP_NOT_B = 4'd7,
    OP_SHL_A = 4'd8,
    OP_SHL_B = 4'd9,
    OP_SHR_A = 4'd10,
    OP_SHR_B = 4'd11,
    OP_MUL   = 4'd12,
    OP_SBB   = 4'd13,
    OP_LDI   = 4'd14,
    OP_CMP   = 4'd15
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic sign;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: loads on start, retires one multiplier bit per
// cycle and pulses done once the full 2*WIDTH product is in place.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  import alu_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= CW'(WIDTH);
        busy   <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        // last bit retired on this edge; product is final next cycle
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_exec_unit.sv
// Register-file ALU executing one command at a time; MUL goes to the iterative
// multiplier, everything else resolves in a single EXEC cycle.
//
// state | meaning
// IDLE  | ready, waiting for In_Valid
// EXEC  | single-cycle op evaluated, writeback on exit
// MUL   | waiting on alu_mul_seq, writeback on exit
// DONE  | Out_Valid pulse, Result/flags stable
module alu_exec_unit #(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [3:0]       Opcode,
  input  logic [AW-1:0]    Src_A,
  input  logic [AW-1:0]    Src_B,
  input  logic [AW-1:0]    Dst,
  input  logic [WIDTH-1:0] Imm,
  output logic             Out_Valid,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Zero,
  output logic             Sign,
  output logic             Overflow
);
  import alu_pkg::*;

  localparam int MSB = WIDTH - 1;

  state_t             state, state_nxt;
  opcode_t            op_in, op_q;
  logic [AW-1:0]      dst_q;
  logic [WIDTH-1:0]   imm_q, a_q, b_q;
  logic               cin_q;
  logic [WIDTH-1:0]   regs [NREGS];
  flags_t             flags_q, alu_flags;
  logic [WIDTH-1:0]   result_q, alu_res;
  logic               out_valid_q;
  logic               accept, mul_start, mul_done, wb_en;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     sum;
  logic               alu_c, alu_v;

  assign op_in     = opcode_t'(Opcode);
  assign In_Ready  = (state == ST_IDLE);
  assign accept    = In_Valid & In_Ready;
  assign mul_start = accept && (op_in == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (Clk),
    .rst     (Rst),
    .start   (mul_start),
    .a       (regs[Src_A]),
    .b       (regs[Src_B]),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wb_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (op_in == OP_MUL) ? ST_MUL : ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_DONE;
        wb_en     = 1'b1;
      end
      ST_MUL: begin
        if (mul_done) begin
          state_nxt = ST_DONE;
          wb_en     = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Carry doubles as borrow on the subtract family (bit WIDTH of the difference).
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC: begin
        sum     = {1'b0, a_q} + {1'b0, b_q}
                + {{WIDTH{1'b0}}, (op_q == OP_ADC) ? cin_q : 1'b0};
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_q[MSB] == b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        sum     = {1'b0, a_q} - {1'b0, b_q}
                - {{WIDTH{1'b0}}, (op_q == OP_SBB) ? cin_q : 1'b0};
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_q[MSB] != b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      OP_OR:    alu_res = a_q | b_q;
      OP_AND:   alu_res = a_q & b_q;
      OP_XOR:   alu_res = a_q ^ b_q;
      OP_NOT_A: alu_res = ~a_q;
      OP_NOT_B: alu_res = ~b_q;
      OP_SHL_A: begin alu_res = a_q << 1; alu_c = a_q[MSB]; end
      OP_SHL_B: begin alu_res = b_q << 1; alu_c = b_q[MSB]; end
      OP_SHR_A: begin alu_res = a_q >> 1; alu_c = a_q[0];   end
      OP_SHR_B: begin alu_res = b_q >> 1; alu_c = b_q[0];   end
      OP_MUL: begin
        alu_res = mul_product[MSB:0];
        alu_c   = |mul_product[2*WIDTH-1:WIDTH];
      end
      OP_LDI:   alu_res = imm_q;
      default:  alu_res = '0;
    endcase
    alu_flags.carry    = alu_c;
    alu_flags.zero     = (alu_res == '0);
    alu_flags.sign     = alu_res[MSB];
    alu_flags.overflow = alu_v;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      op_q        <= OP_ADD;
      dst_q       <= '0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      flags_q     <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= wb_en;
      if (accept) begin
        op_q  <= op_in;
        dst_q <= Dst;
        imm_q <= Imm;
        a_q   <= regs[Src_A];
        b_q   <= regs[Src_B];
        cin_q <= flags_q.carry;
      end
      if (wb_en) begin
        result_q <= alu_res;
        if (op_q != OP_CMP) begin
          regs[dst_q] <= alu_res;
        end
        if (op_q != OP_LDI) begin
          flags_q <= alu_flags;
        end
      end
    end
  end

  assign Out_Valid = out_valid_q;
  assign Result    = result_q;
  assign Carry     = flags_q.carry;
  assign Zero      = flags_q.zero;
  assign Sign      = flags_q.sign;
  assign Overflow  = flags_q.overflow;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit (WIDTH=8, NREGS=8); expected results
// and flags below are hand-computed. Flags are compared as {C,Z,S,V}.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       In_Valid = 1'b0;
  logic       In_Ready;
  logic [3:0] Opcode = 4'd0;
  logic [2:0] Src_A = 3'd0, Src_B = 3'd0, Dst = 3'd0;
  logic [7:0] Imm = 8'd0;
  logic       Out_Valid;
  logic [7:0] Result;
  logic       Carry, Zero, Sign, Overflow;

  int n_chk  = 0;
  int n_pass = 0;

  alu_exec_unit #(.WIDTH(8), .NREGS(8)) dut (
    .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Opcode(Opcode), .Src_A(Src_A), .Src_B(Src_B), .Dst(Dst), .Imm(Imm),
    .Out_Valid(Out_Valid), .Result(Result),
    .Carry(Carry), .Zero(Zero), .Sign(Sign), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issues one command, returns cycles from the accept cycle to Out_Valid.
  // With hold set, In_Valid stays high (as an LDI R<d>=0x55) while busy.
  task automatic issue(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d, input logic [7:0] imm, input bit hold,
                       output int lat);
    int guard = 0;
    while (!In_Ready && guard < 20) begin
      @(posedge Clk); #1; guard++;
    end
    Opcode = op; Src_A = a; Src_B = b; Dst = d; Imm = imm; In_Valid = 1'b1;
    @(posedge Clk); #1;
    lat = 1;
    if (hold) begin
      Opcode = OP_LDI; Imm = 8'h55;
    end else begin
      In_Valid = 1'b0;
    end
    while (!Out_Valid && lat < 40) begin
      if (hold) check("busy_in_ready", {31'd0, In_Ready}, 32'd0);
      @(posedge Clk); #1; lat++;
    end
    In_Valid = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [2:0] a,
                       input logic [2:0] b, input logic [2:0] d, input logic [7:0] imm,
                       input bit hold, input logic [7:0] exp_res, input logic [3:0] exp_flg,
                       input int exp_lat);
    int lat;
    issue(op, a, b, d, imm, hold, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, {24'd0, Result}, {24'd0, exp_res});
    check({tag, "_flg"}, {28'd0, Carry, Zero, Sign, Overflow}, {28'd0, exp_flg});
    @(posedge Clk); #1;
    check({tag, "_pulse"}, {31'd0, Out_Valid}, 32'd0);
  endtask

  initial begin
    bit saw_ov;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    check("rst_ready", {31'd0, In_Ready}, 32'd1);
    check("rst_result", {24'd0, Result}, 32'd0);
    check("rst_flags", {28'd0, Carry, Zero, Sign, Overflow}, 32'd0);
    check("rst_ov", {31'd0, Out_Valid}, 32'd0);

    for (int r = 0; r < 8; r++)
      do_op("rd_rst", OP_OR, 3'(r), 3'(r), 3'd0, 8'h00, 1'b0, 8'h00, 4'b0100, 2);

    do_op("ldi_r1", OP_LDI, 3'd0, 3'd0, 3'd1, 8'hF0, 1'b0, 8'hF0, 4'b0100, 2);
    do_op("ldi_r2", OP_LDI, 3'd0, 3'd0, 3'd2, 8'h20, 1'b0, 8'h20, 4'b0100, 2);
    do_op("add",    OP_ADD, 3'd1, 3'd2, 3'd3, 8'h00, 1'b0, 8'h10, 4'b1000, 2);
    do_op("adc",    OP_ADC, 3'd1, 3'd2, 3'd4, 8'h00, 1'b0, 8'h11, 4'b1000, 2);
    do_op("sub",    OP_SUB, 3'd2, 3'd1, 3'd5, 8'h00, 1'b0, 8'h30, 4'b1000, 2);
    do_op("sbb",    OP_SBB, 3'd2, 3'd1, 3'd5, 8'h00, 1'b0, 8'h2F, 4'b1000, 2);
    do_op("cmp",    OP_CMP, 3'd1, 3'd1, 3'd3, 8'h00, 1'b0, 8'h00, 4'b0100, 2);
    do_op("rd_r3",  OP_OR,  3'd3, 3'd3, 3'd0, 8'h00, 1'b0, 8'h10, 4'b0000, 2);
    do_op("mul0",   OP_MUL, 3'd1, 3'd2, 3'd6, 8'h00, 1'b1, 8'h00, 4'b1100, 10);
    do_op("rd_r6a", OP_OR,  3'd6, 3'd6, 3'd0, 8'h00, 1'b0, 8'h00, 4'b0100, 2);
    do_op("ldi_0d", OP_LDI, 3'd0, 3'd0, 3'd1, 8'h0D, 1'b0, 8'h0D, 4'b0100, 2);
    do_op("ldi_0b", OP_LDI, 3'd0, 3'd0, 3'd2, 8'h0B, 1'b0, 8'h0B, 4'b0100, 2);
    do_op("mul1",   OP_MUL, 3'd1, 3'd2, 3'd6, 8'h00, 1'b0, 8'h8F, 4'b0010, 10);
    do_op("rd_r6b", OP_OR,  3'd6, 3'd6, 3'd0, 8'h00, 1'b0, 8'h8F, 4'b0010, 2);
    do_op("ldi_r7", OP_LDI, 3'd0, 3'd0, 3'd7, 8'h81, 1'b0, 8'h81, 4'b0010, 2);
    do_op("shl_a",  OP_SHL_A, 3'd7, 3'd0, 3'd0, 8'h00, 1'b0, 8'h02, 4'b1000, 2);
    do_op("shr_a",  OP_SHR_A, 3'd7, 3'd0, 3'd0, 8'h00, 1'b0, 8'h40, 4'b1000, 2);
    do_op("ldi_7f", OP_LDI, 3'd0, 3'd0, 3'd1, 8'h7F, 1'b0, 8'h7F, 4'b1000, 2);
    do_op("ldi_01", OP_LDI, 3'd0, 3'd0, 3'd2, 8'h01, 1'b0, 8'h01, 4'b1000, 2);
    do_op("add_ov", OP_ADD, 3'd1, 3'd2, 3'd3, 8'h00, 1'b0, 8'h80, 4'b0011, 2);
    do_op("xor",    OP_XOR, 3'd1, 3'd2, 3'd0, 8'h00, 1'b0, 8'h7E, 4'b0000, 2);
    do_op("and",    OP_AND, 3'd1, 3'd2, 3'd0, 8'h00, 1'b0, 8'h01, 4'b0000, 2);
    do_op("not_a",  OP_NOT_A, 3'd1, 3'd2, 3'd0, 8'h00, 1'b0, 8'h80, 4'b0010, 2);
    do_op("not_b",  OP_NOT_B, 3'd1, 3'd2, 3'd0, 8'h00, 1'b0, 8'hFE, 4'b0010, 2);
    do_op("shl_b",  OP_SHL_B, 3'd1, 3'd2, 3'd0, 8'h00, 1'b0, 8'h02, 4'b0000, 2);
    do_op("shr_b",  OP_SHR_B, 3'd1, 3'd2, 3'd0, 8'h00, 1'b0, 8'h00, 4'b1100, 2);
    do_op("sub_neg", OP_SUB, 3'd2, 3'd1, 3'd0, 8'h00, 1'b0, 8'h82, 4'b1010, 2);

    // Abort a MUL (0x7F*0x01 into R6, which holds 0x8F) three cycles in.
    saw_ov = 1'b0;
    Opcode = OP_MUL; Src_A = 3'd1; Src_B = 3'd2; Dst = 3'd6; In_Valid = 1'b1;
    @(posedge Clk); #1;
    In_Valid = 1'b0;
    check("abort_busy", {31'd0, In_Ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk); #1;
      saw_ov |= Out_Valid;
    end
    Rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk); #1;
      saw_ov |= Out_Valid;
    end
    Rst = 1'b0;
    check("abort_ready", {31'd0, In_Ready}, 32'd1);
    check("abort_result", {24'd0, Result}, 32'd0);
    check("abort_flags", {28'd0, Carry, Zero, Sign, Overflow}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk); #1;
      saw_ov |= Out_Valid;
    end
    check("abort_no_ov", {31'd0, saw_ov}, 32'd0);
    do_op("rd_r6c", OP_OR, 3'd6, 3'd6, 3'd0, 8'h00, 1'b0, 8'h00, 4'b0100, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameters SHALL be:
 - WIDTH, 8, datapath width in bits (>=4)
 - NREGS, 8, register count (power of 2, >=2); AW = log2(NREGS) derived.
REQ-002 Ports SHALL be:
 - Clk  in  1  clock; one clock domain, all logic on rising edge
 - Rst  in  1  reset, synchronous, active-high
 - In_Valid  in  1  command valid
 - In_Ready  out  1  unit can accept command
 - Opcode  in  4  operation select
 - Src_A, Src_B  in  AW  source register addresses
 - Dst  in  AW  destination register address
 - Imm  in  WIDTH  immediate for LDI
 - Out_Valid  out  1  one-cycle completion pulse
 - Result  out  WIDTH  result of completed op, held until next completion
 - Carry, Zero, Sign, Overflow  out  1 each  flag register outputs

Function
REQ-003 Command SHALL be accepted on a rising edge where In_Valid & In_Ready; Opcode, Dst, Imm, Reg[Src_A], Reg[Src_B] SHALL be latched at that edge.
REQ-004 In_Ready SHALL be 1 only in IDLE; In_Valid outside IDLE SHALL be ignored.
REQ-005 FSM states: IDLE, EXEC, MUL, DONE; IDLE->EXEC on accept (non-MUL), IDLE->MUL on accept (MUL), EXEC->DONE, MUL->DONE after WIDTH iteration cycles, DONE->IDLE.
REQ-006 Register writeback, flag update and Result update SHALL occur on the edge leaving EXEC or MUL; Out_Valid SHALL be 1 for exactly the DONE cycle.
REQ-007 Latency (accept edge to Out_Valid high): 2 cycles single-cycle ops, WIDTH+2 cycles MUL; throughput one command per 3 cycles minimum.
REQ-008 Opcodes: 0 ADD, 1 OR, 2 AND, 3 XOR, 4 SUB (A-B), 5 ADC (A+B+Carry), 6 NOT_A, 7 NOT_B, 8 SHL_A, 9 SHL_B, 10 SHR_A, 11 SHR_B, 12 MUL (low WIDTH bits of A*B, unsigned), 13 SBB (A-B-Carry), 14 LDI (Dst<=Imm), 15 CMP (A-B, flags only).
REQ-009 ADC/SBB SHALL use the registered Carry flag as held at the accept edge.
REQ-010 Carry: carry-out bit WIDTH for ADD/ADC; borrow for SUB/SBB/CMP; bit shifted out for shifts (MSB for SHL, LSB for SHR); 1 if MUL high half nonzero; 0 for logic/NOT.
REQ-011 Overflow: signed two's-complement overflow for ADD/ADC/SUB/SBB/CMP; 0 otherwise.
REQ-012 Zero = (result==0); Sign = result[WIDTH-1]; computed from full WIDTH result.
REQ-013 CMP SHALL update flags and Result without register writeback; LDI SHALL write register and Result but leave all flags unchanged.
REQ-014 Src/Dst may coincide; operands SHALL be pre-write values (no hazard possible, single command in flight).
REQ-015 MUL SHALL be iterative shift-add, one bit per cycle, WIDTH cycles in MUL state.

Reset
REQ-016 While Rst=1 at an edge: state<=IDLE, all registers<=0, flags<=0, Result<=0, Out_Valid<=0; In_Ready=1 first cycle after Rst deasserts.
REQ-017 Rst during EXEC or MUL SHALL abort the command with no writeback, no flag update, no Out_Valid.

Structure
REQ-018 Shared package alu_pkg SHALL hold opcode enum, FSM state enum, flag struct {Carry, Zero, Sign, Overflow}.
REQ-019 Sub-module alu_mul_seq (start, WIDTH-parametrised operands, done, product) SHALL implement REQ-015; all other ops combinational inside alu_exec_unit.

Verification (WIDTH=8, NREGS=8)
REQ-020 Reset -> all Reg=0x00, flags 0, Result 0x00, In_Ready=1 cycle after Rst low.
REQ-021 LDI R1=0xF0, LDI R2=0x20, ADD R3=R1,R2 -> Result 0x10, Carry=1, Zero=0, Sign=0, Overflow=0; Out_Valid 2 cycles after accept; then ADC R4=R1,R2 -> 0x11.
REQ-022 SUB R5=R2,R1 (0x20-0xF0) -> 0x30, Carry=1; CMP R1,R1 -> Zero=1, Carry=0, Result 0x00, Dst unchanged.
REQ-023 MUL R6=R1,R2 -> 0x00, Carry=1, Zero=1; Out_Valid 10 cycles after accept; In_Ready=0 and extra In_Valid ignored throughout.
REQ-024 LDI R7=0x81; SHL_A R7 -> 0x02, Carry=1; SHR_A R7 -> 0x40, Carry=1; LDI R1=0x7F, LDI R2=0x01, ADD -> 0x80, Overflow=1, Sign=1.
REQ-025 Rst asserted 3 cycles into MUL -> no Out_Valid, Reg[Dst]=0x00, accepts new command after Rst low.
